// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute control for the 8-bit ALU datapath.
// Optional retire counter output `retired` is built when SEQ_RETIRE_COUNT_EN is defined.
module alu_sequencer #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            done,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      instr,
    output logic [2:0]      lut_idx,
    input  logic [PC_W-1:0] lut_target,
    output logic [2:0]      rf_ra_addr,
    output logic [2:0]      rf_rb_addr,
    output logic [2:0]      rf_wr_addr,
    output logic            rf_we,
    output logic            rf_wr_sel,
    output logic [2:0]      alu_cmd,
    output logic [2:0]      typeselect,
    output logic [3:0]      immed,
    output logic            sc_in,
    input  logic            sc_o,
    input  logic            notequal,
    input  logic            lessthan,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [15:0]     retired
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state;
    logic [PC_W-1:0] pc;
    logic [8:0] ir;
    logic carry, sc_lat;
    logic [2:0] op;
    logic [1:0] msel;
    logic is_mem, is_ldst, is_load, is_branch, writes, taken, active;
    assign op = ir[8:6];
    assign msel = ir[4:3];
    assign imem_addr = pc;
    assign sc_in = carry;
    // instruction decode and state-gated ALU/register-file controls
    always_comb begin
        is_mem = op == 3'b010;
        is_ldst = is_mem && !msel[1];
        is_load = is_mem && msel == 2'b00;
        is_branch = op == 3'b011 || op == 3'b110;
        writes = op == 3'b000 || op == 3'b001 || op == 3'b101 || op == 3'b100 || (is_mem && msel != 2'b01);
        taken = (op == 3'b011 && notequal) || (op == 3'b110 && lessthan);
        active = state == EXEC || state == MEM || state == WB;
        alu_cmd = active ? op : 3'd0;
        typeselect = (active && op == 3'b001) ? ir[5:3] : 3'd0;
        immed = (active && op == 3'b100) ? ir[5:2] : 4'd0;
        lut_idx = is_branch ? ir[2:0] : 3'd0;
        rf_ra_addr = op == 3'b100 ? {1'b0, ir[1:0]} : (is_mem && msel == 2'b11) ? 3'd0 : is_branch ? ir[5:3] : ir[2:0];
        rf_rb_addr = op == 3'b101 ? ir[5:3] : 3'd0;
        rf_wr_addr = !writes ? 3'd0 : op == 3'b100 ? {1'b0, ir[1:0]} : (is_mem && msel == 2'b10) ? 3'd0 : ir[2:0];
    end
    // sequencer FSM with registered strobes, pc, carry and instruction register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            pc <= '0;
            ir <= '0;
            carry <= 1'b0;
            sc_lat <= 1'b0;
            done <= 1'b0;
            rf_we <= 1'b0;
            rf_wr_sel <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we <= 1'b0;
`ifdef SEQ_RETIRE_COUNT_EN
            retired <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= FETCH;
                    pc <= '0;
`ifdef SEQ_RETIRE_COUNT_EN
                    retired <= '0;
`endif
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    ir <= instr;
                    state <= EXEC;
                end
                EXEC: begin
                    sc_lat <= sc_o;
                    if (op == 3'b111) begin
                        state <= HALT;
                        done <= 1'b1;
`ifdef SEQ_RETIRE_COUNT_EN
                        retired <= retired + 16'd1;
`endif
                    end else begin
                        pc <= taken ? lut_target : pc + 1'b1;
                        if (is_ldst) begin
                            state <= MEM;
                            dmem_req <= 1'b1;
                            dmem_we <= msel[0];
                        end else begin
                            state <= WB;
                            rf_we <= writes;
                        end
                    end
                end
                MEM: if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    dmem_we <= 1'b0;
                    rf_we <= is_load;
                    rf_wr_sel <= is_load;
                    state <= WB;
                end
                WB: begin
                    rf_we <= 1'b0;
                    rf_wr_sel <= 1'b0;
                    if (op == 3'b001 && ir[5:3] <= 3'd5) carry <= sc_lat;
`ifdef SEQ_RETIRE_COUNT_EN
                    retired <= retired + 16'd1;
`endif
                    state <= FETCH;
                end
                HALT: if (start) begin
                    state <= FETCH;
                    pc <= '0;
                    done <= 1'b0;
`ifdef SEQ_RETIRE_COUNT_EN
                    retired <= '0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer (retire counter checks with SEQ_RETIRE_COUNT_EN).
module tb_alu_sequencer;
    localparam int PC_W = 10;
    localparam logic [8:0] HALT_I = 9'b111_000000;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic done, rf_we, rf_wr_sel, sc_in, sc_o, notequal, lessthan, dmem_req, dmem_we;
    logic dmem_ack = 1'b0;
    logic [PC_W-1:0] imem_addr, lut_target;
    logic [8:0] instr = '0;
    logic [2:0] lut_idx, rf_ra_addr, rf_rb_addr, rf_wr_addr, alu_cmd, typeselect;
    logic [3:0] immed;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0] retired;
`endif
    logic [8:0] imem [0:1023];
    logic lt_val = 1'b0;
    int ack_delay = 3, req_cnt = 0, req_hi = 0;
    int n_checks = 0, n_fail = 0;
    typedef struct packed {logic [2:0] addr; logic sel; logic [2:0] cmd; logic [3:0] imm; logic sc;} wr_t;
    wr_t exp_wr[$];
    logic exp_mem[$];
    logic req_q = 1'b0;

    alu_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .done(done), .imem_addr(imem_addr),
        .instr(instr), .lut_idx(lut_idx), .lut_target(lut_target), .rf_ra_addr(rf_ra_addr),
        .rf_rb_addr(rf_rb_addr), .rf_wr_addr(rf_wr_addr), .rf_we(rf_we), .rf_wr_sel(rf_wr_sel),
        .alu_cmd(alu_cmd), .typeselect(typeselect), .immed(immed), .sc_in(sc_in), .sc_o(sc_o),
        .notequal(notequal), .lessthan(lessthan), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack)
`ifdef SEQ_RETIRE_COUNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    // environment models: instruction memory, ALU flags, branch table, data memory
    always @(posedge clk) instr <= imem[imem_addr];
    assign sc_o = (alu_cmd == 3'b001) && (typeselect == 3'b000);
    assign notequal = rf_ra_addr == 3'd1;
    assign lessthan = lt_val;
    assign lut_target = lut_idx == 3'd5 ? 10'h3A0 : lut_idx == 3'd6 ? 10'h3FF : 10'h055;
    always @(negedge clk) begin
        req_cnt = dmem_req ? req_cnt + 1 : 0;
        if (dmem_req) req_hi = req_hi + 1;
        dmem_ack = dmem_req && req_cnt == ack_delay;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [2:0] a, input logic s, input logic [2:0] c, input logic [3:0] i, input logic sc);
        wr_t w;
        w.addr = a; w.sel = s; w.cmd = c; w.imm = i; w.sc = sc;
        exp_wr.push_back(w);
    endtask

    // monitor: pops scoreboard entries on each register write and each memory request
    always @(negedge clk) begin
        wr_t w;
        if (rf_we) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rf_we: got write to R%0d, expected no write", rf_wr_addr);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", rf_wr_addr, w.addr);
                check("wr_sel", rf_wr_sel, w.sel);
                check("wr_alu_cmd", alu_cmd, w.cmd);
                check("wr_immed", immed, w.imm);
                check("wr_sc_in", sc_in, w.sc);
            end
        end
        if (dmem_req && !req_q) begin
            if (exp_mem.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_dmem_req: got request we=%0b, expected none", dmem_we);
            end else check("dmem_we", dmem_we, exp_mem.pop_front());
        end
        req_q = dmem_req;
    end

    task automatic do_reset();
        for (int i = 0; i < 1024; i++) imem[i] = HALT_I;
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        check(name, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_done", done, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_pc", imem_addr, 0);
        check("rst_alu_cmd", alu_cmd, 0);
        check("rst_immed", immed, 0);
        check("rst_sc_in", sc_in, 0);
        // reset while stuck in MEM: request drops, no write
        imem[0] = 9'b010_0_00_011;
        ack_delay = 100;
        exp_mem.push_back(1'b0);
        pulse_start();
        for (int i = 0; i < 10 && !dmem_req; i++) @(negedge clk);
        check("mem_req_seen", dmem_req, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mem_rst_req", dmem_req, 0);
        check("mem_rst_we", rf_we, 0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mem_rst_idle_pc", imem_addr, 0);
        check("mem_rst_idle_req", dmem_req, 0);
        ack_delay = 3;
        // halfset R1 imm 5 then halt, with an ignored start mid-instruction
        do_reset();
        imem[0] = 9'b100_0101_01;
        imem[1] = HALT_I;
        push_wr(3'd1, 1'b0, 3'b100, 4'h5, 1'b0);
        pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        check("hs_done_c7", done, 0);
        @(negedge clk);
        check("hs_done_c8", done, 1);
        check("hs_pc", imem_addr, 10'd1);
        check("hs_immed_halt", immed, 0);
`ifdef SEQ_RETIRE_COUNT_EN
        check("hs_retired", retired, 16'd2);
`endif
        // shift carry: shl-1 sets carry, inc leaves it, shl-with-carry sees it
        do_reset();
        imem[0] = 9'b001_000_010;
        imem[1] = 9'b001_110_010;
        imem[2] = 9'b001_001_010;
        imem[3] = HALT_I;
        push_wr(3'd2, 1'b0, 3'b001, 4'h0, 1'b0);
        push_wr(3'd2, 1'b0, 3'b001, 4'h0, 1'b1);
        push_wr(3'd2, 1'b0, 3'b001, 4'h0, 1'b1);
        pulse_start();
        wait_done("sh_done");
        check("sh_carry_end", sc_in, 0);
        check("sh_pc", imem_addr, 10'd3);
`ifdef SEQ_RETIRE_COUNT_EN
        check("sh_retired", retired, 16'd4);
        pulse_start();
        check("sh_retired_clr", retired, 16'd0);
        check("sh_restart_done", done, 0);
`endif
        // blt taken and not taken
        do_reset();
        lt_val = 1'b1;
        imem[0] = 9'b110_001_101;
        pulse_start();
        wait_done("blt_t_done");
        check("blt_taken_pc", imem_addr, 10'h3A0);
        do_reset();
        lt_val = 1'b0;
        imem[0] = 9'b110_001_101;
        pulse_start();
        wait_done("blt_nt_done");
        check("blt_not_taken_pc", imem_addr, 10'd1);
        // bneq taken to 0x3FF, then not-taken wraps pc to 0
        do_reset();
        imem[0] = 9'b011_001_110;
        imem[1023] = 9'b011_010_110;
        pulse_start();
        for (int i = 0; i < 20 && imem_addr != 10'h3FF; i++) @(negedge clk);
        check("bneq_taken_pc", imem_addr, 10'h3FF);
        imem[0] = HALT_I;
        wait_done("wrap_done");
        check("wrap_pc", imem_addr, 10'd0);
        // load with 3-cycle ack, then store
        do_reset();
        imem[0] = 9'b010_0_00_100;
        imem[1] = 9'b010_0_01_011;
        imem[2] = HALT_I;
        exp_mem.push_back(1'b0);
        exp_mem.push_back(1'b1);
        push_wr(3'd4, 1'b1, 3'b010, 4'h0, 1'b0);
        req_hi = 0;
        pulse_start();
        wait_done("ldst_done");
        check("ldst_req_cycles", req_hi, 6);
        check("ldst_pc", imem_addr, 10'd2);
        repeat (2) @(negedge clk);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("mem_queue_empty", exp_mem.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
